// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl
// Moore-style controller for a shared-memory multicycle RV32I datapath
// (single ALU, single memory, IR/OldPC/A/B/ALUOut/Data registers).
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   op/func3/func7    instruction fields taken from IR
//   zero, lt          ALU flags used by the BRANCH state
//   pc_write, ir_write, mem_write, reg_write   write strobes (forced 0 in reset)
//   adr_src, alu_src_a, alu_src_b, result_src, alu_ctrl, imm_src   datapath selects
//   state_o           current state encoding (debug)
//   instret           retired-instruction counter (CNT_W bits, wraps)
//   illegal           sticky illegal-opcode flag
//
// Configuration macro: RV_ILLEGAL_TRAP_EN
//   defined   -> unknown opcodes park the FSM in TRAP and set illegal
//   undefined -> unknown opcodes retire as NOPs, illegal tied to 0
module riscv_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             zero,
    input  logic             lt,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic [2:0]       alu_ctrl,
    output logic [2:0]       imm_src,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC_R = 4'd6,  S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_JALR   = 4'd11,
        S_LINK   = 4'd12, S_LUI    = 4'd13, S_TRAP   = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instret;

    logic       w_pc_write, w_adr_src, w_mem_write, w_ir_write, w_reg_write;
    logic [1:0] w_alu_src_a, w_alu_src_b, w_result_src;
    logic [2:0] w_alu_ctrl, w_imm_src;

    // State register and retired-instruction counter (a retire is any entry into FETCH)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_instret <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_next;
            if (w_next == S_FETCH) begin
                r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_instret <= r_instret;
            end
        end
    end

    // Next-state decode and per-state datapath controls
    always_comb begin
        w_next       = r_state;
        w_pc_write   = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_result_src = 2'b00;
        w_alu_ctrl   = 3'b000;
        w_imm_src    = 3'b000;
        case (r_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_pc_write   = 1'b1;
                w_next       = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut <= OldPC + imm: branch target, or jump target for JAL
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                w_imm_src   = (op == OP_JAL) ? 3'b011 : 3'b010;
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXEC_R;
                    OP_I:              w_next = S_EXEC_I;
                    OP_BR:             w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI:            w_next = S_LUI;
`ifdef RV_ILLEGAL_TRAP_EN
                    default:           w_next = S_TRAP;
`else
                    default:           w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_imm_src   = (op == OP_STORE) ? 3'b001 : 3'b000;
                w_next      = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_adr_src = 1'b1;
                w_next    = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWR: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_EXEC_R: begin
                w_alu_src_a = 2'b10;
                case ({func7, func3})
                    {7'b0100000, 3'b000}: w_alu_ctrl = 3'b001;
                    {7'b0000000, 3'b010}: w_alu_ctrl = 3'b101;
                    {7'b0000000, 3'b110}: w_alu_ctrl = 3'b011;
                    {7'b0000000, 3'b111}: w_alu_ctrl = 3'b010;
                    default:              w_alu_ctrl = 3'b000;
                endcase
                w_next = S_ALUWB;
            end
            S_EXEC_I: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                case (func3)
                    3'b010:  w_alu_ctrl = 3'b101;
                    3'b100:  w_alu_ctrl = 3'b111;
                    3'b110:  w_alu_ctrl = 3'b011;
                    3'b111:  w_alu_ctrl = 3'b010;
                    default: w_alu_ctrl = 3'b000;
                endcase
                w_next = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a = 2'b10;
                w_alu_ctrl  = 3'b001;
                case (func3)
                    3'b000:  w_pc_write = zero;
                    3'b001:  w_pc_write = ~zero;
                    3'b100:  w_pc_write = lt;
                    3'b101:  w_pc_write = ~lt;
                    default: w_pc_write = 1'b0;
                endcase
                w_next = S_FETCH;
            end
            S_JAL: begin
                // PC <= ALUOut (target) while the ALU forms the link value OldPC+4
                w_imm_src   = 3'b011;
                w_pc_write  = 1'b1;
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_next      = S_ALUWB;
            end
            S_JALR: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b01;
                w_result_src = 2'b10;
                w_pc_write   = 1'b1;
                w_next       = S_LINK;
            end
            S_LINK: begin
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_LUI: begin
                w_imm_src    = 3'b100;
                w_result_src = 2'b11;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_TRAP: begin
`ifdef RV_ILLEGAL_TRAP_EN
                w_next = S_TRAP;
`else
                w_next = S_FETCH;
`endif
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

`ifdef RV_ILLEGAL_TRAP_EN
    logic r_illegal;

    // Sticky illegal flag, set on entry into TRAP and cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_illegal <= 1'b0;
        end else if (w_next == S_TRAP) begin
            r_illegal <= 1'b1;
        end else begin
            r_illegal <= r_illegal;
        end
    end

    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    // Reset gates every output combinationally so an aborted state cannot write
    assign pc_write   = w_pc_write  & ~reset;
    assign ir_write   = w_ir_write  & ~reset;
    assign mem_write  = w_mem_write & ~reset;
    assign reg_write  = w_reg_write & ~reset;
    assign adr_src    = w_adr_src   & ~reset;
    assign alu_src_a  = reset ? 2'b00  : w_alu_src_a;
    assign alu_src_b  = reset ? 2'b00  : w_alu_src_b;
    assign result_src = reset ? 2'b00  : w_result_src;
    assign alu_ctrl   = reset ? 3'b000 : w_alu_ctrl;
    assign imm_src    = reset ? 3'b000 : w_imm_src;
    assign state_o    = r_state;
    assign instret    = r_instret;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl: walks each instruction class through
// its state sequence, checking state_o, strobes, selects and instret against
// hand-computed values. Outputs are sampled on the falling clock edge.
module tb_riscv_multicycle_ctrl;

    logic        clk;
    logic        reset;
    logic [6:0]  op;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        zero;
    logic        lt;
    logic        pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [2:0]  alu_ctrl, imm_src;
    logic [3:0]  state_o;
    logic [31:0] instret;
    logic        illegal;

    int n_total;
    int n_bad;

    riscv_multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .func3(func3), .func7(func7),
        .zero(zero), .lt(lt), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .alu_ctrl(alu_ctrl), .imm_src(imm_src), .state_o(state_o),
        .instret(instret), .illegal(illegal)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [6:0] f7, input logic [2:0] f3,
                             input logic z, input logic l);
        op = o; func7 = f7; func3 = f3; zero = z; lt = l;
    endtask

    // Run a two-operand instruction (R or I) from FETCH; checks ALU control in EXEC
    task automatic run_alu(input string tag, input logic [6:0] o, input logic [6:0] f7,
                           input logic [2:0] f3, input logic [3:0] exec_st,
                           input logic [2:0] exp_ctrl, input logic [31:0] exp_ret);
        set_instr(o, f7, f3, 1'b0, 1'b0);
        tick(); chk({tag, "_dec"}, {28'd0, state_o}, 32'd1);
        tick(); chk({tag, "_exst"}, {28'd0, state_o}, {28'd0, exec_st});
        chk({tag, "_ctrl"}, {29'd0, alu_ctrl}, {29'd0, exp_ctrl});
        tick(); chk({tag, "_wb"}, {28'd0, state_o}, 32'd8);
        chk({tag, "_wbrw"}, {31'd0, reg_write}, 32'd1);
        tick(); chk({tag, "_ret"}, instret, exp_ret);
    endtask

    // Run a branch from FETCH and check the taken decision
    task automatic run_br(input string tag, input logic [2:0] f3, input logic z,
                          input logic l, input logic exp_pcw, input logic [31:0] exp_ret);
        set_instr(7'b1100011, 7'd0, f3, z, l);
        tick(); chk({tag, "_dec"}, {28'd0, state_o}, 32'd1);
        tick(); chk({tag, "_st"}, {28'd0, state_o}, 32'd9);
        chk({tag, "_pcw"}, {31'd0, pc_write}, {31'd0, exp_pcw});
        chk({tag, "_sub"}, {29'd0, alu_ctrl}, 32'd1);
        tick(); chk({tag, "_ret"}, instret, exp_ret);
        chk({tag, "_fetch"}, {28'd0, state_o}, 32'd0);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        set_instr(7'd0, 7'd0, 3'd0, 1'b0, 1'b0);
        tick(); tick();
        chk("rst_state", {28'd0, state_o}, 32'd0);
        chk("rst_pcw", {31'd0, pc_write}, 32'd0);
        chk("rst_irw", {31'd0, ir_write}, 32'd0);
        chk("rst_srcb", {30'd0, alu_src_b}, 32'd0);
        chk("rst_ret", instret, 32'd0);
        chk("rst_ill", {31'd0, illegal}, 32'd0);
        reset = 1'b0;
        #1;
        chk("fetch_irw", {31'd0, ir_write}, 32'd1);
        chk("fetch_pcw", {31'd0, pc_write}, 32'd1);
        chk("fetch_srcb", {30'd0, alu_src_b}, 32'd2);
        chk("fetch_res", {30'd0, result_src}, 32'd2);

        // lw: 0,1,2,3,4,0
        set_instr(7'b0000011, 7'd0, 3'b010, 1'b0, 1'b0);
        tick(); chk("lw_dec", {28'd0, state_o}, 32'd1);
        chk("lw_dec_imm", {29'd0, imm_src}, 32'd2);
        chk("lw_dec_srca", {30'd0, alu_src_a}, 32'd1);
        tick(); chk("lw_adr", {28'd0, state_o}, 32'd2);
        chk("lw_adr_imm", {29'd0, imm_src}, 32'd0);
        chk("lw_adr_srca", {30'd0, alu_src_a}, 32'd2);
        tick(); chk("lw_rd", {28'd0, state_o}, 32'd3);
        chk("lw_rd_adr", {31'd0, adr_src}, 32'd1);
        chk("lw_rd_rw", {31'd0, reg_write}, 32'd0);
        tick(); chk("lw_wb", {28'd0, state_o}, 32'd4);
        chk("lw_wb_rw", {31'd0, reg_write}, 32'd1);
        chk("lw_wb_res", {30'd0, result_src}, 32'd1);
        tick(); chk("lw_end", {28'd0, state_o}, 32'd0);
        chk("lw_ret", instret, 32'd1);

        // sw: 0,1,2,5,0
        set_instr(7'b0100011, 7'd0, 3'b010, 1'b0, 1'b0);
        tick(); chk("sw_dec", {28'd0, state_o}, 32'd1);
        chk("sw_dec_mw", {31'd0, mem_write}, 32'd0);
        tick(); chk("sw_adr", {28'd0, state_o}, 32'd2);
        chk("sw_adr_imm", {29'd0, imm_src}, 32'd1);
        tick(); chk("sw_wr", {28'd0, state_o}, 32'd5);
        chk("sw_wr_mw", {31'd0, mem_write}, 32'd1);
        chk("sw_wr_adr", {31'd0, adr_src}, 32'd1);
        tick(); chk("sw_ret", instret, 32'd2);
        chk("sw_mw_off", {31'd0, mem_write}, 32'd0);

        run_alu("sub",  7'b0110011, 7'b0100000, 3'b000, 4'd6, 3'b001, 32'd3);
        run_alu("or",   7'b0110011, 7'b0000000, 3'b110, 4'd6, 3'b011, 32'd4);
        run_alu("and",  7'b0110011, 7'b0000000, 3'b111, 4'd6, 3'b010, 32'd5);
        run_alu("slt",  7'b0110011, 7'b0000000, 3'b010, 4'd6, 3'b101, 32'd6);
        run_alu("rdef", 7'b0110011, 7'b0000001, 3'b000, 4'd6, 3'b000, 32'd7);
        run_alu("xori", 7'b0010011, 7'b0100000, 3'b100, 4'd7, 3'b111, 32'd8);
        run_alu("andi", 7'b0010011, 7'b0000000, 3'b111, 4'd7, 3'b010, 32'd9);

        run_br("beq_t", 3'b000, 1'b1, 1'b0, 1'b1, 32'd10);
        run_br("beq_n", 3'b000, 1'b0, 1'b0, 1'b0, 32'd11);
        run_br("bne_t", 3'b001, 1'b0, 1'b0, 1'b1, 32'd12);
        run_br("blt_t", 3'b100, 1'b0, 1'b1, 1'b1, 32'd13);
        run_br("bge_t", 3'b101, 1'b0, 1'b0, 1'b1, 32'd14);
        run_br("bge_n", 3'b101, 1'b0, 1'b1, 1'b0, 32'd15);
        run_br("bxx_n", 3'b010, 1'b1, 1'b1, 1'b0, 32'd16);

        // jal: 0,1,10,8,0
        set_instr(7'b1101111, 7'd0, 3'd0, 1'b0, 1'b0);
        tick(); chk("jal_dec_imm", {29'd0, imm_src}, 32'd3);
        tick(); chk("jal_st", {28'd0, state_o}, 32'd10);
        chk("jal_pcw", {31'd0, pc_write}, 32'd1);
        chk("jal_srca", {30'd0, alu_src_a}, 32'd1);
        chk("jal_srcb", {30'd0, alu_src_b}, 32'd2);
        tick(); chk("jal_wb", {28'd0, state_o}, 32'd8);
        tick(); chk("jal_ret", instret, 32'd17);

        // lui: 0,1,13,0
        set_instr(7'b0110111, 7'd0, 3'd0, 1'b0, 1'b0);
        tick(); tick(); chk("lui_st", {28'd0, state_o}, 32'd13);
        chk("lui_res", {30'd0, result_src}, 32'd3);
        chk("lui_imm", {29'd0, imm_src}, 32'd4);
        chk("lui_rw", {31'd0, reg_write}, 32'd1);
        tick(); chk("lui_ret", instret, 32'd18);

        // unknown opcode
        set_instr(7'b1111111, 7'd0, 3'd0, 1'b0, 1'b0);
        tick(); chk("ill_dec", {28'd0, state_o}, 32'd1);
        tick();
`ifdef RV_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            chk("trap_st", {28'd0, state_o}, 32'd14);
            chk("trap_ill", {31'd0, illegal}, 32'd1);
            chk("trap_ret", instret, 32'd18);
            chk("trap_pcw", {31'd0, pc_write}, 32'd0);
            tick();
        end
        reset = 1'b1;
        tick();
        chk("trap_rst_ill", {31'd0, illegal}, 32'd0);
        reset = 1'b0;
`else
        chk("nop_st", {28'd0, state_o}, 32'd0);
        chk("nop_ret", instret, 32'd19);
        chk("nop_ill", {31'd0, illegal}, 32'd0);
`endif

        // jalr: 0,1,11,12 then reset in LINK
        set_instr(7'b1100111, 7'd0, 3'd0, 1'b0, 1'b0);
        tick(); chk("jalr_dec", {28'd0, state_o}, 32'd1);
        tick(); chk("jalr_st", {28'd0, state_o}, 32'd11);
        chk("jalr_pcw", {31'd0, pc_write}, 32'd1);
        chk("jalr_res", {30'd0, result_src}, 32'd2);
        tick(); chk("link_st", {28'd0, state_o}, 32'd12);
        chk("link_rw", {31'd0, reg_write}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_rw", {31'd0, reg_write}, 32'd0);
        chk("abort_st", {28'd0, state_o}, 32'd0);
        chk("abort_ret", instret, 32'd0);
        chk("abort_srca", {30'd0, alu_src_a}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_irw", {31'd0, ir_write}, 32'd1);
        tick(); chk("post_dec", {28'd0, state_o}, 32'd1);
        chk("post_ret", instret, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
- Moore-style FSM controller that sequences a shared-memory multicycle RV32I datapath: single ALU, single memory, plus IR, OldPC, A, B, ALUOut and Data registers.
- Decodes op/func3/func7 and issues per-state register enables, mux selects, ALU control and immediate select.
- Sits beside the datapath in the CPU top level and supersedes the single-cycle controller.

Parameters:
- CNT_W, 32, width of the instret retired-instruction counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- op  in  7  IR[6:0].
- func3  in  3  IR[14:12].
- func7  in  7  IR[31:25].
- zero  in  1  ALU result == 0.
- lt  in  1  signed rs1 < rs2 (ALU sub sign).
- pc_write  out  1  PC load enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  data memory write strobe.
- ir_write  out  1  IR and OldPC load enable.
- reg_write  out  1  register file write enable.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = ImmExt, 10 = constant 4.
- result_src  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt.
- alu_ctrl  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt, 111 xor.
- imm_src  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- state_o  out  4  current state encoding (debug).
- instret  out  CNT_W  count of retired instructions.
- illegal  out  1  illegal opcode flag (see Optional Feature).

Behaviour:
- Reset (async):
  - State <= FETCH (0), instret <= 0, illegal <= 0.
  - While reset is high, every strobe (pc_write, ir_write, mem_write, reg_write) is forced to 0.
  - Select outputs are 0 during reset.
- Outputs are a function of the state register, plus op/func3/func7/zero/lt where noted. Unlisted outputs default to 0.
- State encodings:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXEC_R, 7 EXEC_I, 8 ALUWB, 9 BRANCH, 10 JAL, 11 JALR, 12 LINK, 13 LUI, 14 TRAP.
- FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_ctrl=000, result_src=10, pc_write=1. Next state DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, imm_src=010, alu_ctrl=000, so ALUOut = branch target. Next state by op:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXEC_R.
  - 0010011 -> EXEC_I.
  - 1100011 -> BRANCH.
  - 1101111 -> JAL.
  - 1100111 -> JALR.
  - 0110111 -> LUI.
  - Any other op -> illegal handling (see Optional Feature).
- MEMADR: alu_src_a=10, alu_src_b=01, alu_ctrl=000; imm_src=000 for load, 001 for store. Next MEMRD (load) or MEMWR (store).
- MEMRD: adr_src=1, result_src=00. Next MEMWB.
- MEMWB: result_src=01, reg_write=1. Next FETCH.
- MEMWR: adr_src=1, result_src=00, mem_write=1. Next FETCH.
- EXEC_R: alu_src_a=10, alu_src_b=00. alu_ctrl by {func7, func3}:
  - 0000000/000 -> add; 0100000/000 -> sub; 0000000/010 -> slt; 0000000/110 -> or; 0000000/111 -> and.
  - Any other combination -> add.
  - Next ALUWB.
- EXEC_I: alu_src_a=10, alu_src_b=01, imm_src=000. alu_ctrl by func3:
  - 000 add, 010 slt, 100 xor, 110 or, 111 and; any other -> add.
  - Next ALUWB.
- ALUWB: result_src=00, reg_write=1. Next FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_ctrl=001, result_src=00.
  - pc_write = taken, where taken is: 000 & zero | 001 & ~zero | 100 & lt | 101 & ~lt.
  - Any other func3: not taken.
  - Next FETCH.
- JAL: imm_src=011, with ALUOut still holding the branch target from DECODE.
  - In DECODE, imm_src is 011 when op = 1101111 so that the J immediate forms the target.
  - JAL asserts pc_write=1 with result_src=00, and alu_src_a=01, alu_src_b=10, alu_ctrl=000 so the ALU computes OldPC+4.
  - Next ALUWB, which writes rd = OldPC+4.
- JALR: alu_src_a=10, alu_src_b=01, imm_src=000, alu_ctrl=000, result_src=10, pc_write=1. Next LINK.
- LINK: alu_src_a=01, alu_src_b=10, alu_ctrl=000, result_src=10, reg_write=1. Next FETCH.
- LUI: imm_src=100, result_src=11, reg_write=1. Next FETCH.
- Latencies in cycles including FETCH: lw 5, sw 4, R 4, I 4, branch 3, jal 4, jalr 4, lui 3.
- instret increments by 1 (mod 2^CNT_W, wraps silently) on every transition into FETCH that does not come from reset.
- Reset asserted mid-instruction: any write strobe of the aborted state is suppressed immediately (combinational gating). There is no partial retire; instret is cleared.

Optional Feature:
- Macro RV_ILLEGAL_TRAP_EN.
- Defined:
  - DECODE with an unknown op -> TRAP.
  - TRAP asserts illegal=1 (registered, sticky) and all strobes 0, and stays in TRAP until reset.
  - instret is frozen.
- Undefined:
  - An unknown op is treated as a NOP: DECODE -> FETCH and instret increments.
  - illegal is tied to 0 and state 14 is unreachable.

Test Plan:
- Release reset, then feed lw (op 0000011): state_o sequence 0,1,2,3,4,0; reg_write=1 only in state 4 with result_src=01; instret=1.
- sw (op 0100011): sequence 0,1,2,5,0; mem_write=1 only in state 5, adr_src=1, imm_src=001 in state 2.
- sub (func7 0100000, func3 000): alu_ctrl=001 in state 6. or (func7 0, func3 110): alu_ctrl=011.
- beq with zero=1: pc_write=1 in state 9. beq with zero=0: pc_write=0. bge with lt=0: pc_write=1. bge with lt=1: pc_write=0.
- jalr: pc_write=1 in state 11 with result_src=10; reg_write=1 in state 12. Assert reset during state 12: reg_write drops to 0 in the same cycle, state_o=0, instret=0.
- op 1111111:
  - With RV_ILLEGAL_TRAP_EN: state 14, illegal=1 held for 10 cycles, instret unchanged.
  - Without: returns to 0, instret +1.
